seq_pattern_detector: RTL and testbench

- Downstream receiver for the serial status-pattern generator. Samples its 1-bit output on each bit-rate tick and hunts for the 12-bit frame.
- Acquires and holds frame alignment, and reports lock, frame phase and error statistics.
- Sits on the same slow bit-tick domain as the generator, clocked from the board clock iCLK.

---
 rtl/seqdet_pkg.sv | 27 ++
 rtl/seqdet_popcount.sv | 28 ++
 rtl/seq_pattern_detector.sv | 189 ++++++++++++++++++
 tb/tb_seq_pattern_detector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared definitions for the serial status-frame detector:
// state encoding, default frame, phase width and the phase step helper.
package seqdet_pkg;

    // Alignment state machine encoding
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } seqdet_state_e;

    // Default frame: MSB is the first bit on the wire
    localparam int          DEF_PLEN    = 12;
    localparam logic [11:0] DEF_PATTERN = 12'b010001100110;

    // Width of the bit-index-within-frame counter
    localparam int PHASE_W = 4;

    // Advance the in-frame bit index, wrapping from the last bit back to 0
    function automatic logic [PHASE_W-1:0] phase_step(
        input logic [PHASE_W-1:0] phase,
        input logic [PHASE_W-1:0] last
    );
        return (phase == last) ? '0 : phase + PHASE_W'(1);
    endfunction

endpackage

// File: rtl/seqdet_popcount.sv
// Combinational population count of a W-bit vector.
// Used only when per-bit error weighting (SEQDET_BITERR_EN) is built in.
module seqdet_popcount #(
    parameter int W  = 12,
    parameter int CW = 4
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    logic [W-1:0][CW-1:0] terms;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_term
            assign terms[gi] = CW'(bits[gi]);
        end
    endgenerate

    // Sum the zero-extended bit terms
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + terms[i];
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial frame detector: shifts in one bit per iTICK, hunts for PATTERN,
// acquires and holds frame alignment, reports lock/phase/error statistics.
// Optional macro SEQDET_BITERR_EN: a mismatching locked frame adds the
// number of wrong bits to the error counter instead of a flat 1.
module seq_pattern_detector
    import seqdet_pkg::*;
#(
    parameter int             PLEN     = DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = PLEN'(DEF_PATTERN),
    parameter int             LOCK_CNT = 2,
    parameter int             LOSS_CNT = 3,
    parameter int             ERRW     = 8
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iTICK,
    input  logic               iSIG,
    output logic               oMATCH,
    output logic               oFRAME,
    output logic               oLOCK,
    output logic [PHASE_W-1:0] oPHASE,
    output logic [ERRW-1:0]    oERRCNT
);

    localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int MISS_W = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);
    localparam int CNT_W  = $clog2(PLEN + 1);
    // One bit of headroom so the raw sum can be compared against saturation
    localparam int SUM_W  = ((ERRW > CNT_W) ? ERRW : CNT_W) + 1;

    localparam logic [GOOD_W-1:0]  LOCK_TGT   = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_TGT   = MISS_W'(LOSS_CNT);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PLEN - 1);
    localparam logic [SUM_W-1:0]   ERR_MAX    = {{(SUM_W-ERRW){1'b0}}, {ERRW{1'b1}}};

    seqdet_state_e     state_reg,  state_next;
    logic [PLEN-1:0]   window_reg, window_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic [GOOD_W-1:0] good_reg,   good_next;
    logic [MISS_W-1:0] miss_reg,   miss_next;
    logic [ERRW-1:0]   err_reg,    err_next;
    logic              match_reg,  match_next;
    logic              frame_reg,  frame_next;

    // Shift-register view including the bit arriving this tick
    logic [PLEN-1:0]   window_tick;
    logic              hit;
    logic              at_boundary;
    logic [PHASE_W-1:0] phase_adv;
    logic [GOOD_W-1:0] good_inc;
    logic [MISS_W-1:0] miss_inc;
    logic [SUM_W-1:0]  err_inc;
    logic [SUM_W-1:0]  err_sum;
    logic [ERRW-1:0]   err_sat;

    assign window_tick = {window_reg[PLEN-2:0], iSIG};
    assign hit         = (window_tick == PATTERN);
    assign at_boundary = (phase_reg == PHASE_LAST);
    assign phase_adv   = phase_step(phase_reg, PHASE_LAST);
    assign good_inc    = good_reg + GOOD_W'(1);
    assign miss_inc    = miss_reg + MISS_W'(1);

`ifdef SEQDET_BITERR_EN
    logic [CNT_W-1:0] bit_errs;

    seqdet_popcount #(
        .W  (PLEN),
        .CW (CNT_W)
    ) u_popcount (
        .bits  (window_tick ^ PATTERN),
        .count (bit_errs)
    );

    assign err_inc = SUM_W'(bit_errs);
`else
    assign err_inc = SUM_W'(1);
`endif

    assign err_sum = SUM_W'(err_reg) + err_inc;
    assign err_sat = (err_sum > ERR_MAX) ? ERR_MAX[ERRW-1:0] : err_sum[ERRW-1:0];

    // Next-state logic: everything holds between ticks, pulses self-clear
    always_comb begin
        state_next  = state_reg;
        window_next = window_reg;
        phase_next  = phase_reg;
        good_next   = good_reg;
        miss_next   = miss_reg;
        err_next    = err_reg;
        match_next  = 1'b0;
        frame_next  = 1'b0;

        if (iTICK) begin
            window_next = window_tick;
            match_next  = hit;

            case (state_reg)
                SEARCH: begin
                    if (hit) begin
                        phase_next = '0;
                        good_next  = GOOD_W'(1);
                        if (LOCK_CNT <= 1) begin
                            state_next = LOCKED;
                            miss_next  = '0;
                        end else begin
                            state_next = VERIFY;
                        end
                    end
                end

                VERIFY: begin
                    phase_next = phase_adv;
                    // Only whole frames are compared; mid-frame windows are shifted data
                    if (at_boundary) begin
                        frame_next = 1'b1;
                        if (hit) begin
                            good_next = good_inc;
                            if (good_inc == LOCK_TGT) begin
                                state_next = LOCKED;
                                miss_next  = '0;
                            end
                        end else begin
                            state_next = SEARCH;
                            good_next  = '0;
                            phase_next = '0;
                        end
                    end
                end

                LOCKED: begin
                    phase_next = phase_adv;
                    if (at_boundary) begin
                        frame_next = 1'b1;
                        if (hit) begin
                            miss_next = '0;
                        end else begin
                            err_next = err_sat;
                            if (miss_inc == LOSS_TGT) begin
                                state_next = SEARCH;
                                phase_next = '0;
                                good_next  = '0;
                                miss_next  = '0;
                            end else begin
                                miss_next = miss_inc;
                            end
                        end
                    end
                end

                default: begin
                    state_next = SEARCH;
                    phase_next = '0;
                    good_next  = '0;
                    miss_next  = '0;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset that overrides any tick
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_reg  <= SEARCH;
            window_reg <= '0;
            phase_reg  <= '0;
            good_reg   <= '0;
            miss_reg   <= '0;
            err_reg    <= '0;
            match_reg  <= 1'b0;
            frame_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            window_reg <= window_next;
            phase_reg  <= phase_next;
            good_reg   <= good_next;
            miss_reg   <= miss_next;
            err_reg    <= err_next;
            match_reg  <= match_next;
            frame_reg  <= frame_next;
        end
    end

    assign oMATCH  = match_reg;
    assign oFRAME  = frame_reg;
    assign oLOCK   = (state_reg == LOCKED);
    assign oPHASE  = phase_reg;
    assign oERRCNT = err_reg;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: one tick every 4 clocks,
// outputs sampled on the falling edge after the tick's capturing edge.
// A second instance with a 2-bit error counter exercises saturation.
module tb_seq_pattern_detector;

`ifdef SEQDET_BITERR_EN
    localparam int COST_M   = 2;    // frame with bits 5 and 7 flipped
    localparam int COST_INV = 12;   // fully inverted frame
`else
    localparam int COST_M   = 1;
    localparam int COST_INV = 1;
`endif

    logic       iCLK;
    logic       iRST_N;
    logic       iTICK;
    logic       iSIG;
    logic       match_a, frame_a, lock_a;
    logic [3:0] phase_a;
    logic [7:0] err_a;
    logic       match_b, frame_b, lock_b;
    logic [3:0] phase_b;
    logic [1:0] err_b;

    int total;
    int bad;
    int exp_ea;
    int exp_eb;

    logic [11:0] pat;
    logic [11:0] mask57;

    seq_pattern_detector dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iTICK   (iTICK),
        .iSIG    (iSIG),
        .oMATCH  (match_a),
        .oFRAME  (frame_a),
        .oLOCK   (lock_a),
        .oPHASE  (phase_a),
        .oERRCNT (err_a)
    );

    seq_pattern_detector #(.ERRW(2)) dut2 (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iTICK   (iTICK),
        .iSIG    (iSIG),
        .oMATCH  (match_b),
        .oFRAME  (frame_b),
        .oLOCK   (lock_b),
        .oPHASE  (phase_b),
        .oERRCNT (err_b)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int addsat(input int cur, input int inc, input int maxv);
        return (cur + inc > maxv) ? maxv : cur + inc;
    endfunction

    // One bit: 3 idle clocks then a one-clock tick; returns on the falling
    // edge right after the tick was captured
    task automatic tick_bit(input logic b);
        repeat (3) @(negedge iCLK);
        iSIG  = b;
        iTICK = 1'b1;
        @(negedge iCLK);
        iTICK = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] f);
        for (int i = 11; i >= 0; i--) tick_bit(f[i]);
    endtask

    // Boundary outputs of the main instance plus both error counters
    task automatic chk_all(input string tag, input logic m, input logic f,
                           input logic l, input logic [3:0] p);
        chk({tag, ".match"}, match_a, m);
        chk({tag, ".frame"}, frame_a, f);
        chk({tag, ".lock"},  lock_a,  l);
        chk({tag, ".phase"}, phase_a, p);
        chk({tag, ".err8"},  err_a,   exp_ea[15:0]);
        chk({tag, ".err2"},  err_b,   exp_eb[15:0]);
        $display("step %s: match=%0d frame=%0d lock=%0d phase=%0d err8=%0d err2=%0d",
                 tag, match_a, frame_a, lock_a, phase_a, err_a, err_b);
    endtask

    task automatic corrupt(input string tag, input logic [11:0] f, input int cost,
                           input logic lock_exp);
        send_frame(f);
        exp_ea = addsat(exp_ea, cost, 255);
        exp_eb = addsat(exp_eb, cost, 3);
        chk_all(tag, 1'b0, 1'b1, lock_exp, 4'd0);
    endtask

    initial begin
        int idx;
        logic em, ef, el;
        logic [3:0] ep;

        total  = 0;
        bad    = 0;
        exp_ea = 0;
        exp_eb = 0;
        pat    = 12'b010001100110;
        mask57 = 12'b000010100000;
        iRST_N = 1'b0;
        iTICK  = 1'b0;
        iSIG   = 1'b0;

        // Reset state
        repeat (3) @(negedge iCLK);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        iRST_N = 1'b1;

        // All-zero input never acquires anything
        for (int k = 1; k <= 100; k++) begin
            tick_bit(1'b0);
            chk("zeros.match", match_a, 1'b0);
            chk("zeros.frame", frame_a, 1'b0);
            chk("zeros.lock",  lock_a,  1'b0);
            chk("zeros.err",   err_a,   16'd0);
        end
        $display("step zeros: 100 ticks, lock=%0d err8=%0d", lock_a, err_a);

        // Continuous pattern: match at 12, lock at 24, phase walks 0..11
        for (int k = 1; k <= 24; k++) begin
            idx = 11 - ((k - 1) % 12);
            tick_bit(pat[idx]);
            em = (k % 12 == 0);
            ef = (k == 24);
            el = (k == 24);
            ep = (k <= 12) ? 4'd0 : 4'((k - 12) % 12);
            chk("acq.match", match_a, em);
            chk("acq.frame", frame_a, ef);
            chk("acq.lock",  lock_a,  el);
            chk("acq.phase", phase_a, ep);
        end
        $display("step acquire: match=%0d frame=%0d lock=%0d phase=%0d",
                 match_a, frame_a, lock_a, phase_a);
        send_frame(pat);
        chk_all("clean1", 1'b1, 1'b1, 1'b1, 4'd0);

        // Single corrupted frame keeps lock, counts errors
        corrupt("bits57", pat ^ mask57, COST_M, 1'b1);
        send_frame(pat);
        chk_all("clean2", 1'b1, 1'b1, 1'b1, 4'd0);

        // Two more corrupted frames: lock survives only if the clean frame cleared miss
        corrupt("missclr_a", pat ^ mask57, COST_M, 1'b1);
        corrupt("missclr_b", pat ^ mask57, COST_M, 1'b1);
        send_frame(pat);
        chk_all("clean3", 1'b1, 1'b1, 1'b1, 4'd0);

        // Three consecutive bad frames drop lock
        corrupt("loss_a", pat ^ mask57, COST_M, 1'b1);
        corrupt("loss_b", pat ^ mask57, COST_M, 1'b1);
        corrupt("loss_c", pat ^ mask57, COST_M, 1'b0);

        // Relock after two clean frames
        send_frame(pat);
        chk_all("relock1", 1'b1, 1'b0, 1'b0, 4'd0);
        send_frame(pat);
        chk_all("relock2", 1'b1, 1'b1, 1'b1, 4'd0);

        // Fully inverted frames: 2-bit counter pinned at 3
        corrupt("inv_a", ~pat, COST_INV, 1'b1);
        send_frame(pat);
        chk_all("clean4", 1'b1, 1'b1, 1'b1, 4'd0);
        corrupt("inv_b", ~pat, COST_INV, 1'b1);
        chk("sat.err2", err_b, 16'd3);
        send_frame(pat);
        chk_all("clean5", 1'b1, 1'b1, 1'b1, 4'd0);

        // Reset mid-frame while locked, with a tick in the same cycle
        for (int i = 11; i >= 7; i--) tick_bit(pat[i]);
        chk("mid.phase", phase_a, 16'd5);
        chk("mid.lock",  lock_a,  1'b1);
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b0;
        iTICK  = 1'b1;
        iSIG   = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        iTICK  = 1'b0;
        exp_ea = 0;
        exp_eb = 0;
        chk_all("midrst", 1'b0, 1'b0, 1'b0, 4'd0);

        // Fresh acquisition needs a full 12-tick match
        for (int i = 11; i >= 1; i--) tick_bit(pat[i]);
        chk("post.t11.match", match_a, 1'b0);
        chk("post.t11.lock",  lock_a,  1'b0);
        tick_bit(pat[0]);
        chk_all("post.t12", 1'b1, 1'b0, 1'b0, 4'd0);
        send_frame(pat);
        chk_all("post.t24", 1'b1, 1'b1, 1'b1, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
